// File: rtl/ctrl_cfg_extractor.sv
// Control-packet parser: turns one stage's table-write packets into
// buffered {rtype, addr, data} commands behind a first-word fall-through FIFO.
module ctrl_cfg_extractor #(
  parameter int          C_S_AXIS_DATA_WIDTH  = 256,
  parameter int          C_S_AXIS_TUSER_WIDTH = 128,
  parameter logic [7:0]  STAGE_ID             = 8'd0,
  parameter int          FIFO_DEPTH_BITS      = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    ctrl_s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  ctrl_s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   ctrl_s_axis_tuser,
  input  logic                              ctrl_s_axis_tvalid,
  input  logic                              ctrl_s_axis_tlast,
  output logic                              cfg_valid,
  input  logic                              cfg_ready,
  output logic [3:0]                        cfg_rtype,
  output logic [7:0]                        cfg_addr,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    cfg_data,
  output logic [15:0]                       cfg_pkt_cnt,
  output logic [15:0]                       cfg_err_cnt
);

  localparam int DW    = C_S_AXIS_DATA_WIDTH;
  localparam int EW    = DW + 12;
  localparam int PW    = FIFO_DEPTH_BITS;
  localparam int CW    = FIFO_DEPTH_BITS + 1;
  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  logic [1:0]    r_state;
  logic          r_bad;
  logic          r_drop_err;
  logic [3:0]    r_rtype;
  logic [7:0]    r_addr;
  logic [15:0]   r_pkt_cnt;
  logic [15:0]   r_err_cnt;

  logic [EW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_keep_full;
  logic          w_id_match;
  logic          w_pop;
  logic          w_full;
  logic          w_can_push;
  logic          w_data_beat;
  logic          w_push;
  logic          w_beat_bad;
  logic          w_pkt_bad;
  logic [EW-1:0] w_entry;
  logic [EW-1:0] w_head;
  logic          w_unused;

  assign w_unused    = ^ctrl_s_axis_tuser;
  assign w_keep_full = &ctrl_s_axis_tkeep;
  assign w_id_match  = ctrl_s_axis_tdata[119:112] == STAGE_ID;

  assign cfg_valid   = r_count != '0;
  assign w_pop       = cfg_valid & cfg_ready;
  assign w_full      = r_count == L_DEPTH;
  // A full FIFO still takes a beat when its head leaves on the same edge
  assign w_can_push  = ~w_full | w_pop;

  assign w_data_beat = ctrl_s_axis_tvalid & (r_state == S_DATA);
  assign w_push      = w_data_beat & w_keep_full & w_can_push;
  assign w_beat_bad  = ~w_keep_full | ~w_can_push;
  assign w_pkt_bad   = r_bad | w_beat_bad;
  assign w_entry     = {r_rtype, r_addr, ctrl_s_axis_tdata};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_bad      <= 1'b0;
      r_drop_err <= 1'b0;
      r_rtype    <= '0;
      r_addr     <= '0;
      r_pkt_cnt  <= '0;
      r_err_cnt  <= '0;
    end else if (ctrl_s_axis_tvalid) begin
      unique case (r_state)
        S_IDLE: begin
          if (ctrl_s_axis_tlast)
            r_err_cnt <= r_err_cnt + 16'd1;
          else
            r_state <= S_HDR;
        end
        S_HDR: begin
          r_rtype <= ctrl_s_axis_tdata[123:120];
          r_addr  <= ctrl_s_axis_tdata[135:128];
          r_bad   <= 1'b0;
          if (!w_id_match) begin
            r_drop_err <= 1'b0;
            r_state    <= ctrl_s_axis_tlast ? S_IDLE : S_DROP;
          end else if (ctrl_s_axis_tlast) begin
            r_err_cnt <= r_err_cnt + 16'd1;
            r_state   <= S_IDLE;
          end else begin
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_push)
            r_addr <= r_addr + 8'd1;
          if (ctrl_s_axis_tlast) begin
            r_state <= S_IDLE;
            if (w_pkt_bad)
              r_err_cnt <= r_err_cnt + 16'd1;
            else
              r_pkt_cnt <= r_pkt_cnt + 16'd1;
          end else if (w_keep_full && !w_can_push) begin
            r_drop_err <= 1'b1;
            r_state    <= S_DROP;
          end else begin
            r_bad <= r_bad | w_beat_bad;
          end
        end
        S_DROP: begin
          if (ctrl_s_axis_tlast) begin
            r_state <= S_IDLE;
            if (r_drop_err)
              r_err_cnt <= r_err_cnt + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Outputs read as zero while empty so stale RAM never leaks out
  assign w_head      = r_mem[r_rd_ptr];
  assign cfg_rtype   = cfg_valid ? w_head[EW-1 -: 4] : '0;
  assign cfg_addr    = cfg_valid ? w_head[DW+7 -: 8] : '0;
  assign cfg_data    = cfg_valid ? w_head[DW-1:0] : '0;
  assign cfg_pkt_cnt = r_pkt_cnt;
  assign cfg_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_ctrl_cfg_extractor.sv
// Directed bench for ctrl_cfg_extractor: packet table plus
// hand sequences for full-FIFO, runt and reset cases.
module tb_ctrl_cfg_extractor;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [255:0] tdata = '0;
  logic [31:0]  tkeep = '0;
  logic [127:0] tuser = '0;
  logic         tvalid = 1'b0;
  logic         tlast = 1'b0;
  logic         cfg_valid;
  logic         cfg_ready = 1'b1;
  logic [3:0]   cfg_rtype;
  logic [7:0]   cfg_addr;
  logic [255:0] cfg_data;
  logic [15:0]  cfg_pkt_cnt;
  logic [15:0]  cfg_err_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int pid = 0;
  int exp_pkt = 0;
  int exp_err = 0;

  logic [267:0] exp_q[$];
  logic [267:0] got_q[$];

  typedef struct {
    logic [7:0] id;
    logic [3:0] rt;
    logic [7:0] idx;
    int         nd;
    int         badk;
    logic       rdy;
    int         exp_n;
    int         dpkt;
    int         derr;
  } vec_t;

  vec_t tbl[7];

  ctrl_cfg_extractor #(
    .C_S_AXIS_DATA_WIDTH(256),
    .C_S_AXIS_TUSER_WIDTH(128),
    .STAGE_ID(8'd3),
    .FIFO_DEPTH_BITS(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ctrl_s_axis_tdata(tdata),
    .ctrl_s_axis_tkeep(tkeep),
    .ctrl_s_axis_tuser(tuser),
    .ctrl_s_axis_tvalid(tvalid),
    .ctrl_s_axis_tlast(tlast),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_rtype(cfg_rtype),
    .cfg_addr(cfg_addr),
    .cfg_data(cfg_data),
    .cfg_pkt_cnt(cfg_pkt_cnt),
    .cfg_err_cnt(cfg_err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!reset && cfg_valid && cfg_ready)
      got_q.push_back({cfg_rtype, cfg_addr, cfg_data});

  function automatic logic [255:0] mk(input int p, input int k);
    logic [31:0] w;
    w = {p[7:0], k[7:0], 16'hA5C3};
    return {8{w}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [287:0] a,
                     input logic [287:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic beat(input logic [255:0] d, input logic [31:0] k,
                      input logic l);
    tdata  = d;
    tkeep  = k;
    tlast  = l;
    tvalid = 1'b1;
    step();
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic hdr(input logic [7:0] id, input logic [3:0] rt,
                     input logic [7:0] idx, input logic l);
    logic [255:0] d;
    d = mk(pid, 200);
    d[119:112] = id;
    d[123:120] = rt;
    d[135:128] = idx;
    beat(d, '1, l);
  endtask

  task automatic cmp_queues(input string nm);
    chk({nm, "_n"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({nm, "_entry"}, got_q[i], exp_q[i]);
  endtask

  task automatic chk_cnts(input string nm);
    chk({nm, "_pkt"}, cfg_pkt_cnt, exp_pkt[15:0]);
    chk({nm, "_err"}, cfg_err_cnt, exp_err[15:0]);
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int          stored;
    logic [7:0]  a;
    logic [31:0] kp;
    string       nm;
    nm = $sformatf("vec%0d", n);
    exp_q.delete();
    got_q.delete();
    pid++;
    cfg_ready = v.rdy;
    beat(mk(pid, 250), '1, 1'b0);
    hdr(v.id, v.rt, v.idx, v.nd == 0);
    stored = 0;
    for (int k = 0; k < v.nd; k++) begin
      kp = (k == v.badk) ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
      beat(mk(pid, k), kp, k == v.nd - 1);
      if (k != v.badk && stored < v.exp_n) begin
        a = v.idx + stored[7:0];
        exp_q.push_back({v.rt, a, mk(pid, k)});
        stored++;
      end
    end
    if (!v.rdy) begin
      repeat (3) step();
      chk({nm, "_hold_valid"}, cfg_valid, 1'b1);
      chk({nm, "_hold_addr"}, cfg_addr, v.idx);
      chk({nm, "_hold_data"}, cfg_data, mk(pid, 0));
      cfg_ready = 1'b1;
    end
    repeat (24) step();
    exp_pkt += v.dpkt;
    exp_err += v.derr;
    cmp_queues(nm);
    chk_cnts(nm);
  endtask

  initial begin
    tbl[0] = '{8'd3, 4'd2, 8'h10, 3,  -1, 1'b1, 3,  1, 0};
    tbl[1] = '{8'd5, 4'd2, 8'h10, 3,  -1, 1'b1, 0,  0, 0};
    tbl[2] = '{8'd3, 4'd7, 8'hFF, 2,  -1, 1'b1, 2,  1, 0};
    tbl[3] = '{8'd3, 4'd1, 8'h40, 20, -1, 1'b0, 16, 0, 1};
    tbl[4] = '{8'd3, 4'd4, 8'h80, 4,  1,  1'b1, 3,  0, 1};
    tbl[5] = '{8'd3, 4'd3, 8'h20, 0,  -1, 1'b1, 0,  0, 1};
    tbl[6] = '{8'd3, 4'd9, 8'h00, 5,  -1, 1'b1, 5,  1, 0};

    repeat (3) step();
    chk("rst_valid", cfg_valid, 1'b0);
    chk("rst_rtype", cfg_rtype, 4'd0);
    chk("rst_addr", cfg_addr, 8'd0);
    chk("rst_data", cfg_data, 256'd0);
    chk_cnts("rst");
    reset = 1'b0;
    step();

    for (int i = 0; i < 7; i++)
      run_vec(tbl[i], i);

    // full FIFO takes a beat when a pop lands on the same edge
    exp_q.delete();
    got_q.delete();
    pid++;
    cfg_ready = 1'b0;
    beat(mk(pid, 250), '1, 1'b0);
    hdr(8'd3, 4'd5, 8'h60, 1'b0);
    for (int k = 0; k < 16; k++) begin
      beat(mk(pid, k), '1, 1'b0);
      exp_q.push_back({4'd5, 8'(8'h60 + k), mk(pid, k)});
    end
    chk("full_valid", cfg_valid, 1'b1);
    cfg_ready = 1'b1;
    beat(mk(pid, 16), '1, 1'b1);
    exp_q.push_back({4'd5, 8'h70, mk(pid, 16)});
    repeat (24) step();
    exp_pkt += 1;
    cmp_queues("fullpop");
    chk_cnts("fullpop");

    // runt then a good packet with no gap
    exp_q.delete();
    got_q.delete();
    pid++;
    beat(mk(pid, 250), '1, 1'b1);
    beat(mk(pid, 251), '1, 1'b0);
    hdr(8'd3, 4'd6, 8'h30, 1'b0);
    beat(mk(pid, 0), '1, 1'b0);
    beat(mk(pid, 1), '1, 1'b1);
    exp_q.push_back({4'd6, 8'h30, mk(pid, 0)});
    exp_q.push_back({4'd6, 8'h31, mk(pid, 1)});
    repeat (8) step();
    exp_pkt += 1;
    exp_err += 1;
    cmp_queues("runt");
    chk_cnts("runt");

    // reset while in DATA with entries buffered
    pid++;
    cfg_ready = 1'b0;
    beat(mk(pid, 250), '1, 1'b0);
    hdr(8'd3, 4'd2, 8'h10, 1'b0);
    beat(mk(pid, 0), '1, 1'b0);
    beat(mk(pid, 1), '1, 1'b0);
    chk("pre_rst_valid", cfg_valid, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_pkt = 0;
    exp_err = 0;
    chk("midrst_valid", cfg_valid, 1'b0);
    chk("midrst_data", cfg_data, 256'd0);
    chk_cnts("midrst");
    cfg_ready = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
